ldtu_frame_builder: RTL and testbench

Output framing stage directly downstream of the LiTe-DTU encoder. Captures every 32-bit encoded word presented with `Load` into a small first-word-fall-through FIFO and forwards it to the serializer over a valid/ready handshake. After every `FRAME_WORDS` data words it inserts one trailer word carrying frame ID, word count and CRC-12. It absorbs serializer back-pressure and flags lost words.

---
 rtl/ldtu_pkg.sv | 15 +
 rtl/ldtu_frame_builder_if.sv | 24 ++
 rtl/ldtu_crc12_word.sv | 24 ++
 rtl/ldtu_frame_builder.sv | 132 +++++++++++++
 tb/tb_ldtu_frame_builder.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ldtu_pkg.sv
// Shared constants and types for the LiTe-DTU output framing stage:
// trailer tag, CRC-12 parameters, idle word and framer state encoding.
package ldtu_pkg;

   localparam logic [3:0]  LDTU_TRAILER_TAG = 4'b1101;
   localparam logic [11:0] LDTU_CRC_POLY    = 12'h80F;
   localparam logic [11:0] LDTU_CRC_INIT    = 12'hFFF;
   localparam logic [31:0] LDTU_IDLE_WORD   = 32'h5A5A_5A5A;

   typedef enum logic {
      S_DATA    = 1'b0,
      S_TRAILER = 1'b1
   } ldtu_state_e;

endpackage

// File: rtl/ldtu_frame_builder_if.sv
// Encoder-side and serializer-side signals of the frame builder.
// slave: framer view (DATA_32/Load/word_ready in, word stream + status out).
interface ldtu_frame_builder_if;

   logic [31:0] DATA_32;
   logic        Load;
   logic        word_ready;
   logic [31:0] word_out;
   logic        word_valid;
   logic        word_is_trailer;
   logic        overflow;
   logic [7:0]  drop_count;

   modport slave (
      input  DATA_32, Load, word_ready,
      output word_out, word_valid, word_is_trailer, overflow, drop_count
   );

   modport master (
      output DATA_32, Load, word_ready,
      input  word_out, word_valid, word_is_trailer, overflow, drop_count
   );

endinterface

// File: rtl/ldtu_crc12_word.sv
// Combinational CRC-12 (poly 0x80F) update over one 32-bit word, MSB first.
// Ports: crc_in[11:0], data[31:0] -> crc_out[11:0].
module ldtu_crc12_word
   import ldtu_pkg::*;
(
   input  logic [11:0] crc_in,
   input  logic [31:0] data,
   output logic [11:0] crc_out
);

   logic [11:0] c;

   always_comb begin
      c = crc_in;
      for (int i = 31; i >= 0; i--) begin
         if (c[11] ^ data[i])
            c = {c[10:0], 1'b0} ^ LDTU_CRC_POLY;
         else
            c = {c[10:0], 1'b0};
      end
      crc_out = c;
   end

endmodule

// File: rtl/ldtu_frame_builder.sv
// Output framer: FWFT FIFO of encoder words, trailer every FRAME_WORDS words.
// Ports: CLK, reset (sync, active-low), bus (slave modport). Macro: LDTU_FRAME_CRC_EN.
module ldtu_frame_builder
   import ldtu_pkg::*;
#(
   parameter int          FIFO_DEPTH  = 8,
   parameter int          FRAME_WORDS = 50,
   parameter logic [31:0] IDLE_WORD   = LDTU_IDLE_WORD
) (
   input logic                  CLK,
   input logic                  reset,
   ldtu_frame_builder_if.slave  bus
);

   localparam int          AW   = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] PONE = (AW+1)'(1);
   localparam logic [7:0]  FW   = 8'(FRAME_WORDS);

   logic [31:0] mem_q [FIFO_DEPTH];
   logic [AW:0] wptr_q, rptr_q;
   logic        ovf_q;
   logic [7:0]  drop_q;

   ldtu_state_e state_q;
   logic [7:0]  count_q, fid_q;
   logic [7:0]  count_d;
   logic [11:0] crc_field;

   logic        empty, full, valid, hs, pop, push, drop;
   logic [31:0] head;

   assign empty = (wptr_q == rptr_q);
   assign full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) &&
                  (wptr_q[AW] != rptr_q[AW]);
   assign head  = mem_q[rptr_q[AW-1:0]];

   assign valid = (state_q == S_TRAILER) || !empty;
   assign hs    = valid && bus.word_ready;
   assign pop   = hs && (state_q == S_DATA);
   // A pop frees the slot the same cycle, so a full FIFO still accepts.
   assign push  = bus.Load && (!full || pop);
   assign drop  = bus.Load && full && !pop;

   assign count_d = count_q + 8'd1;

`ifdef LDTU_FRAME_CRC_EN
   logic [11:0] crc_q, crc_d;

   ldtu_crc12_word u_crc (
      .crc_in  (crc_q),
      .data    (head),
      .crc_out (crc_d)
   );

   assign crc_field = crc_q;
`else
   assign crc_field = 12'h000;
`endif

   always_ff @(posedge CLK) begin
      if (push)
         mem_q[wptr_q[AW-1:0]] <= bus.DATA_32;
   end

   always_ff @(posedge CLK) begin
      if (!reset) begin
         wptr_q <= '0;
         rptr_q <= '0;
         ovf_q  <= 1'b0;
         drop_q <= '0;
      end else begin
         if (push)
            wptr_q <= wptr_q + PONE;
         if (pop)
            rptr_q <= rptr_q + PONE;
         if (drop) begin
            ovf_q <= 1'b1;
            if (drop_q != 8'hFF)
               drop_q <= drop_q + 8'd1;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!reset) begin
         state_q <= S_DATA;
         count_q <= '0;
         fid_q   <= '0;
`ifdef LDTU_FRAME_CRC_EN
         crc_q   <= LDTU_CRC_INIT;
`endif
      end else begin
         unique case (state_q)
            S_DATA: begin
               if (pop) begin
                  count_q <= count_d;
`ifdef LDTU_FRAME_CRC_EN
                  crc_q   <= crc_d;
`endif
                  if (count_d == FW)
                     state_q <= S_TRAILER;
               end
            end
            S_TRAILER: begin
               if (hs) begin
                  state_q <= S_DATA;
                  count_q <= '0;
                  fid_q   <= fid_q + 8'd1;
`ifdef LDTU_FRAME_CRC_EN
                  crc_q   <= LDTU_CRC_INIT;
`endif
               end
            end
            default: state_q <= S_DATA;
         endcase
      end
   end

   always_comb begin
      bus.word_out = IDLE_WORD;
      if (state_q == S_TRAILER)
         bus.word_out = {LDTU_TRAILER_TAG, fid_q, crc_field, count_q};
      else if (!empty)
         bus.word_out = head;
   end

   assign bus.word_valid      = valid;
   assign bus.word_is_trailer = (state_q == S_TRAILER);
   assign bus.overflow        = ovf_q;
   assign bus.drop_count      = drop_q;

endmodule

// File: tb/tb_ldtu_frame_builder.sv
// Directed bench for ldtu_frame_builder with FRAME_WORDS=4, FIFO_DEPTH=8.
// Vector table for the basic frame, hand sequences for stall/full/wrap/reset.
module tb_ldtu_frame_builder;

   logic CLK;
   logic reset;
   int   total;
   int   bad;

   ldtu_frame_builder_if bus ();

   ldtu_frame_builder #(
      .FIFO_DEPTH  (8),
      .FRAME_WORDS (4),
      .IDLE_WORD   (32'h5A5A_5A5A)
   ) dut (
      .CLK   (CLK),
      .reset (reset),
      .bus   (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic        load;
      logic [31:0] data;
      logic        ready;
      logic        ev;
      logic        et;
      logic [31:0] eo;
   } vec_t;

   function automatic logic [11:0] sw_crc(input logic [31:0] w0, input logic [31:0] w1,
                                          input logic [31:0] w2, input logic [31:0] w3);
      logic [11:0]  c;
      logic [127:0] s;
      c = 12'hFFF;
      s = {w0, w1, w2, w3};
      for (int i = 127; i >= 0; i--) begin
         c[11] = c[11] ^ s[i];
         c = c[11] ? ((c << 1) ^ 12'h80F) : (c << 1);
      end
      return c;
   endfunction

   function automatic logic [31:0] trl(input logic [7:0] id,
                                       input logic [31:0] w0, input logic [31:0] w1,
                                       input logic [31:0] w2, input logic [31:0] w3);
      logic [11:0] c;
`ifdef LDTU_FRAME_CRC_EN
      c = sw_crc(w0, w1, w2, w3);
`else
      c = 12'h000;
`endif
      return {4'hD, id, c, 8'h04};
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", name, act, exp);
      end
   endtask

   task automatic drv(input logic ld, input logic [31:0] d, input logic rdy);
      bus.Load       = ld;
      bus.DATA_32    = d;
      bus.word_ready = rdy;
   endtask

   vec_t        v[6];
   logic [31:0] eo[11];
   logic        ev[11];
   logic        et[11];
   logic [7:0]  exp_id;
   int          ntr;

   initial begin
      total = 0;
      bad   = 0;

      // reset held with Load active
      reset = 1'b0;
      drv(1'b1, 32'hDEAD_BEEF, 1'b1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_valid", 32'(bus.word_valid), 32'd0);
         chk("rst_out", bus.word_out, 32'h5A5A_5A5A);
      end
      chk("rst_trl", 32'(bus.word_is_trailer), 32'd0);
      chk("rst_ovf", 32'(bus.overflow), 32'd0);
      chk("rst_drop", 32'(bus.drop_count), 32'd0);
      drv(1'b0, 32'h0, 1'b1);
      reset = 1'b1;
      tick();

      // basic frame: 1..4 then trailer
      v[0] = '{1'b1, 32'h1, 1'b1, 1'b1, 1'b0, 32'h1};
      v[1] = '{1'b1, 32'h2, 1'b1, 1'b1, 1'b0, 32'h2};
      v[2] = '{1'b1, 32'h3, 1'b1, 1'b1, 1'b0, 32'h3};
      v[3] = '{1'b1, 32'h4, 1'b1, 1'b1, 1'b0, 32'h4};
      v[4] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, trl(8'h00, 32'h1, 32'h2, 32'h3, 32'h4)};
      v[5] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h5A5A_5A5A};
      for (int i = 0; i < 6; i++) begin
         drv(v[i].load, v[i].data, v[i].ready);
         tick();
         chk($sformatf("vec%0d_valid", i), 32'(bus.word_valid), 32'(v[i].ev));
         chk($sformatf("vec%0d_trl", i), 32'(bus.word_is_trailer), 32'(v[i].et));
         chk($sformatf("vec%0d_out", i), bus.word_out, v[i].eo);
      end

      // back-pressure: 10 words into 8 slots
      for (int i = 0; i < 10; i++) begin
         drv(1'b1, 32'hA000_0000 + i, 1'b0);
         tick();
      end
      drv(1'b0, 32'h0, 1'b0);
      chk("bp_ovf", 32'(bus.overflow), 32'd1);
      chk("bp_drop", 32'(bus.drop_count), 32'd2);
      tick();
      chk("bp_hold_valid", 32'(bus.word_valid), 32'd1);
      chk("bp_hold_out", bus.word_out, 32'hA000_0000);
      for (int k = 0; k < 11; k++) begin
         ev[k] = 1'b1;
         et[k] = 1'b0;
      end
      for (int k = 0; k < 4; k++) begin
         eo[k]     = 32'hA000_0000 + k;
         eo[k + 5] = 32'hA000_0004 + k;
      end
      eo[4] = trl(8'h01, 32'hA000_0000, 32'hA000_0001, 32'hA000_0002, 32'hA000_0003);
      et[4] = 1'b1;
      eo[9] = trl(8'h02, 32'hA000_0004, 32'hA000_0005, 32'hA000_0006, 32'hA000_0007);
      et[9] = 1'b1;
      eo[10] = 32'h5A5A_5A5A;
      ev[10] = 1'b0;
      bus.word_ready = 1'b1;
      for (int k = 0; k < 11; k++) begin
         chk($sformatf("bp%0d_out", k), bus.word_out, eo[k]);
         chk($sformatf("bp%0d_valid", k), 32'(bus.word_valid), 32'(ev[k]));
         chk($sformatf("bp%0d_trl", k), 32'(bus.word_is_trailer), 32'(et[k]));
         tick();
      end

      // full FIFO with push and pop in the same cycle
      for (int i = 0; i < 8; i++) begin
         drv(1'b1, 32'hB000_0000 + i, 1'b0);
         tick();
      end
      drv(1'b1, 32'hB000_0008, 1'b1);
      tick();
      drv(1'b0, 32'h0, 1'b1);
      chk("full_drop", 32'(bus.drop_count), 32'd2);
      for (int k = 0; k < 11; k++) begin
         ev[k] = 1'b1;
         et[k] = 1'b0;
      end
      eo[0] = 32'hB000_0001;
      eo[1] = 32'hB000_0002;
      eo[2] = 32'hB000_0003;
      eo[3] = trl(8'h03, 32'hB000_0000, 32'hB000_0001, 32'hB000_0002, 32'hB000_0003);
      et[3] = 1'b1;
      for (int k = 0; k < 4; k++)
         eo[k + 4] = 32'hB000_0004 + k;
      eo[8] = trl(8'h04, 32'hB000_0004, 32'hB000_0005, 32'hB000_0006, 32'hB000_0007);
      et[8] = 1'b1;
      eo[9] = 32'hB000_0008;
      eo[10] = 32'h5A5A_5A5A;
      ev[10] = 1'b0;
      for (int k = 0; k < 11; k++) begin
         chk($sformatf("full%0d_out", k), bus.word_out, eo[k]);
         chk($sformatf("full%0d_valid", k), 32'(bus.word_valid), 32'(ev[k]));
         chk($sformatf("full%0d_trl", k), 32'(bus.word_is_trailer), 32'(et[k]));
         tick();
      end

      // reset with a partial frame pending
      reset = 1'b0;
      tick();
      reset = 1'b1;
      chk("rst2_valid", 32'(bus.word_valid), 32'd0);
      chk("rst2_ovf", 32'(bus.overflow), 32'd0);
      chk("rst2_drop", 32'(bus.drop_count), 32'd0);

      // 257 frames: frame_id wraps 0xFF -> 0x00
      exp_id = 8'h00;
      ntr    = 0;
      for (int f = 0; f < 257; f++) begin
         for (int s = 0; s < 5; s++) begin
            drv(s < 4, 32'(f * 4 + s), 1'b1);
            tick();
            if (bus.word_valid && bus.word_is_trailer) begin
               chk($sformatf("wrap_id%0d", ntr), 32'(bus.word_out[27:20]), 32'(exp_id));
               chk($sformatf("wrap_cnt%0d", ntr), 32'(bus.word_out[7:0]), 32'd4);
               exp_id = exp_id + 8'd1;
               ntr++;
            end
         end
      end
      chk("wrap_ntr", 32'(ntr), 32'd257);
      drv(1'b0, 32'h0, 1'b1);
      tick();

      // reset while a trailer is stalled
      for (int i = 0; i < 4; i++) begin
         drv(1'b1, 32'hC000_0000 + i, 1'b1);
         tick();
      end
      drv(1'b0, 32'h0, 1'b1);
      tick();
      bus.word_ready = 1'b0;
      tick();
      chk("stall_trl", 32'(bus.word_is_trailer), 32'd1);
      chk("stall_out", bus.word_out,
          trl(8'h01, 32'hC000_0000, 32'hC000_0001, 32'hC000_0002, 32'hC000_0003));
      reset = 1'b0;
      tick();
      reset = 1'b1;
      chk("rst3_valid", 32'(bus.word_valid), 32'd0);
      chk("rst3_trl", 32'(bus.word_is_trailer), 32'd0);
      chk("rst3_out", bus.word_out, 32'h5A5A_5A5A);
      for (int i = 0; i < 4; i++) begin
         drv(1'b1, 32'hD000_0000 + i, 1'b1);
         tick();
      end
      drv(1'b0, 32'h0, 1'b1);
      tick();
      chk("post_rst_trl", 32'(bus.word_is_trailer), 32'd1);
      chk("post_rst_out", bus.word_out,
          trl(8'h00, 32'hD000_0000, 32'hD000_0001, 32'hD000_0002, 32'hD000_0003));
      tick();
      chk("post_rst_idle", 32'(bus.word_valid), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
